// File: rtl/pcc_pkg.sv
// Shared types and command-word layout for the point-cloud accelerator DRAM shell.
package pcc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_CMD = 3'd1,
      RD_DAT = 3'd2,
      WR_CMD = 3'd3,
      WR_DAT = 3'd4,
      DONE   = 3'd5
   } pccState_e;

   localparam int CMD_DIR_BIT  = 0;
   localparam int CMD_ADDR_LSB = 1;
   localparam int CMD_NUM_LSB  = 33;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/pcc_if.sv
// Port bundle between the job controller and its word buffer.
interface pcc_if #(
   parameter int DW = 128,
   parameter int AW = 6
);
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrDat;
   logic [AW-1:0] rdAddr;
   logic [DW-1:0] rdDat;

   modport master (output wrEn, wrAddr, wrDat, rdAddr, input rdDat);
   modport slave  (input wrEn, wrAddr, wrDat, rdAddr, output rdDat);
endinterface

// File: rtl/pcc_buf.sv
// Register-array word buffer: synchronous write, combinational read.
module pcc_buf #(
   parameter int DEPTH = 64,
   parameter int DW    = 128,
   parameter int AW    = 6
) (
   input logic  clk,
   pcc_if.slave bus
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (bus.wrEn) mem[bus.wrAddr] <= bus.wrDat;
   end

   assign bus.rdDat = mem[bus.rdAddr];

endmodule

// File: rtl/pcc_top.sv
// DRAM-side loopback shell: reads a block over the shared stream port, buffers it,
// and writes it back at WR_BASE.
//
//   state  | meaning
//   IDLE   | waiting for a start edge, bus owned and quiet
//   RD_CMD | presenting the read command
//   RD_DAT | bus turned around, receiving words into the buffer
//   WR_CMD | presenting the write command for the words received
//   WR_DAT | streaming buffered words back out
//   DONE   | job finished, O_NetFnh set
module pcc_top
   import pcc_pkg::*;
#(
   parameter int                         CLOCK_PERIOD    = 10,
   parameter int                         PORT_WIDTH      = 128,
   parameter int                         DRAM_ADDR_WIDTH = 32,
   parameter int                         ADDR_WIDTH      = 16,
   parameter logic [DRAM_ADDR_WIDTH-1:0] RD_BASE         = '0,
   parameter logic [DRAM_ADDR_WIDTH-1:0] WR_BASE         = 32'h1000,
   parameter int                         XFER_NUM        = 16,
   parameter int                         BUF_DEPTH       = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  I_StartPulse,
   input  logic                  I_BypAsysnFIFO,
   output logic                  O_DatOE,
   inout  wire  [PORT_WIDTH-1:0] IO_Dat,
   inout  wire                   IO_DatVld,
   inout  wire                   IO_DatLast,
   inout  wire                   OI_DatRdy,
   output logic                  O_NetFnh
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_RD_CMD = RD_CMD;
   localparam logic [2:0] S_RD_DAT = RD_DAT;
   localparam logic [2:0] S_WR_CMD = WR_CMD;
   localparam logic [2:0] S_WR_DAT = WR_DAT;
   localparam logic [2:0] S_DONE   = DONE;

   logic [2:0]            state, stateNxt;
   logic                  startD, startEdge, startAcc;
   logic [CW-1:0]         rcnt, wcnt;
   logic                  hs, wrLast;
   logic [PORT_WIDTH-1:0] rdCmd, wrCmd, datDrv;
   logic                  vldDrv, lastDrv;

   // Only the synchronous bypass path exists, so the FIFO select has no effect.
   logic unusedSig;
   assign unusedSig = ^{I_BypAsysnFIFO, 32'(CLOCK_PERIOD)};

   pcc_if #(.DW(PORT_WIDTH), .AW(AW)) bufBus ();

   pcc_buf #(.DEPTH(BUF_DEPTH), .DW(PORT_WIDTH), .AW(AW)) uBuf (
      .clk (clk),
      .bus (bufBus)
   );

   assign hs       = IO_DatVld & OI_DatRdy;
   assign wrLast   = (wcnt == rcnt - CW'(1));
   assign startAcc = startEdge & ((state == S_IDLE) | (state == S_DONE));

   always_comb begin
      rdCmd = '0;
      rdCmd[CMD_DIR_BIT] = DIR_RD;
      rdCmd[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH] = RD_BASE;
      rdCmd[CMD_NUM_LSB +: ADDR_WIDTH] = ADDR_WIDTH'(XFER_NUM);
      wrCmd = '0;
      wrCmd[CMD_DIR_BIT] = DIR_WR;
      wrCmd[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH] = WR_BASE;
      wrCmd[CMD_NUM_LSB +: ADDR_WIDTH] = ADDR_WIDTH'(rcnt);
   end

   always_comb begin
      stateNxt = state;
      case (state)
         S_IDLE:   if (startAcc) stateNxt = S_RD_CMD;
         S_RD_CMD: if (hs) stateNxt = S_RD_DAT;
         S_RD_DAT: if (hs && IO_DatLast) stateNxt = S_WR_CMD;
         S_WR_CMD: if (hs) stateNxt = S_WR_DAT;
         S_WR_DAT: if (hs && wrLast) stateNxt = S_DONE;
         S_DONE:   stateNxt = startAcc ? S_RD_CMD : S_IDLE;
         default:  stateNxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         startD    <= 1'b0;
         startEdge <= 1'b0;
         rcnt      <= '0;
         wcnt      <= '0;
         O_NetFnh  <= 1'b0;
      end else begin
         state     <= stateNxt;
         startD    <= I_StartPulse;
         startEdge <= I_StartPulse & ~startD;
         if (startAcc) begin
            rcnt     <= '0;
            wcnt     <= '0;
            O_NetFnh <= 1'b0;
         end
         // Words past the buffer are still acknowledged but not counted.
         if (state == S_RD_DAT && hs && rcnt != CW'(BUF_DEPTH)) rcnt <= rcnt + CW'(1);
         if (state == S_WR_CMD && hs) wcnt <= '0;
         if (state == S_WR_DAT && hs) wcnt <= wcnt + CW'(1);
         if (state == S_WR_DAT && hs && wrLast) O_NetFnh <= 1'b1;
      end
   end

   assign bufBus.wrEn   = (state == S_RD_DAT) & hs & (rcnt != CW'(BUF_DEPTH));
   assign bufBus.wrAddr = rcnt[AW-1:0];
   assign bufBus.wrDat  = IO_Dat;
   assign bufBus.rdAddr = wcnt[AW-1:0];

   always_comb begin
      datDrv  = '0;
      vldDrv  = 1'b0;
      lastDrv = 1'b0;
      case (state)
         S_RD_CMD: begin
            datDrv = rdCmd;
            vldDrv = 1'b1;
         end
         S_WR_CMD: begin
            datDrv = wrCmd;
            vldDrv = 1'b1;
         end
         S_WR_DAT: begin
            datDrv  = bufBus.rdDat;
            vldDrv  = 1'b1;
            lastDrv = wrLast;
         end
         default: ;
      endcase
   end

   // The bus belongs to the DRAM side only while receiving read data.
   assign O_DatOE    = (state != S_RD_DAT);
   assign IO_Dat     = O_DatOE ? datDrv : 'z;
   assign IO_DatVld  = O_DatOE ? vldDrv : 1'bz;
   assign IO_DatLast = O_DatOE ? lastDrv : 1'bz;
   assign OI_DatRdy  = O_DatOE ? 1'bz : 1'b1;

endmodule

// File: tb/tb_pcc_top.sv
// Bench for pcc_top: DRAM model on the shared port plus a scoreboard of expected
// commands and write-back words.
module tb_pcc_top;

   localparam int PW = 128;
   localparam logic [PW-1:0] RD_CMD16 = 128'h20_0000_0000;
   localparam logic [PW-1:0] WR_CMD16 = 128'h20_0000_2001;
   localparam logic [PW-1:0] WR_CMD5  = 128'h0A_0000_2001;

   typedef struct {
      logic [PW-1:0] word;
      logic          last;
   } exp_t;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          startPulse = 1'b0;
   logic          bypFifo    = 1'b1;
   logic          datOe, netFnh;
   wire  [PW-1:0] ioDat;
   wire           ioVld, ioLast, ioRdy;

   logic [PW-1:0] tbDat  = '0;
   logic          tbVld  = 1'b0;
   logic          tbLast = 1'b0;
   logic          tbRdy  = 1'b1;

   exp_t          expQ[$];
   int            checks = 0;
   int            errors = 0;

   logic [PW-1:0] dram [int];
   bit            mRdActive = 1'b0;
   bit            mWrData   = 1'b0;
   bit            stallEn   = 1'b0;
   int            earlyLast = 0;
   int            mRdAddr, mRdLen, mRdIdx, mWrAddr, mWrIdx, wrCyc;

   assign ioDat  = datOe ? 'z : tbDat;
   assign ioVld  = datOe ? 1'bz : tbVld;
   assign ioLast = datOe ? 1'bz : tbLast;
   assign ioRdy  = datOe ? tbRdy : 1'bz;

   always #5 clk = ~clk;

   pcc_top dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .I_StartPulse   (startPulse),
      .I_BypAsysnFIFO (bypFifo),
      .O_DatOE        (datOe),
      .IO_Dat         (ioDat),
      .IO_DatVld      (ioVld),
      .IO_DatLast     (ioLast),
      .OI_DatRdy      (ioRdy),
      .O_NetFnh       (netFnh)
   );

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // DRAM model: decodes commands, serves read bursts, stores write bursts.
   initial begin
      logic          dutHs, tbHs, sLast;
      logic [PW-1:0] sDat;
      forever begin
         @(negedge clk);
         dutHs = rst_n && datOe && ioVld && ioRdy;
         tbHs  = rst_n && !datOe && tbVld && ioRdy;
         sDat  = ioDat;
         sLast = ioLast;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mRdActive = 1'b0;
            mWrData   = 1'b0;
            tbVld     = 1'b0;
            tbLast    = 1'b0;
            tbRdy     = 1'b1;
         end else begin
            if (dutHs && !mWrData) begin
               if (sDat[0] == 1'b0) begin
                  mRdActive = 1'b1;
                  mRdAddr   = int'(sDat[32:1]);
                  mRdLen    = int'(sDat[48:33]);
                  if (earlyLast > 0 && earlyLast < mRdLen) mRdLen = earlyLast;
                  mRdIdx    = 0;
               end else begin
                  mWrData = 1'b1;
                  mWrAddr = int'(sDat[32:1]);
                  mWrIdx  = 0;
                  wrCyc   = 0;
               end
            end else if (dutHs && mWrData) begin
               dram[mWrAddr + mWrIdx] = sDat;
               mWrIdx++;
               if (sLast) mWrData = 1'b0;
            end
            if (tbHs) begin
               mRdIdx++;
               if (tbLast) mRdActive = 1'b0;
            end
            if (mRdActive) begin
               tbVld  = 1'b1;
               tbDat  = dram[mRdAddr + mRdIdx];
               tbLast = (mRdIdx == mRdLen - 1);
            end else begin
               tbVld  = 1'b0;
               tbLast = 1'b0;
            end
            if (mWrData && stallEn) begin
               wrCyc++;
               tbRdy = ((wrCyc % 4) != 2);
            end else begin
               tbRdy = 1'b1;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every word the DUT hands over.
   initial begin
      bit            holdPend = 1'b0;
      logic [PW-1:0] holdDat  = '0;
      logic          holdLast = 1'b0;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk1("oe_dir", datOe, !mRdActive);
            if (!datOe) chk1("dut_rdy", ioRdy, 1'b1);
            if (holdPend) begin
               chk1("hold_vld", ioVld, 1'b1);
               chk("hold_dat", ioDat, holdDat);
               chk1("hold_last", ioLast, holdLast);
            end
            if (datOe && ioVld && ioRdy) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h expected no word at %0t", ioDat, $time);
               end else begin
                  e = expQ.pop_front();
                  chk("word", ioDat, e.word);
                  chk1("last", ioLast, e.last);
               end
            end
            holdPend = datOe && ioVld && !ioRdy;
            holdDat  = ioDat;
            holdLast = ioLast;
         end else begin
            holdPend = 1'b0;
         end
      end
   end

   task automatic runJob(input bit byp, input bit stall, input int early,
                         input logic [PW-1:0] wrCmd, input int nExp);
      exp_t e;
      bypFifo   = byp;
      stallEn   = stall;
      earlyLast = early;
      for (int i = 0; i <= 16; i++) dram[32'h1000 + i] = '0;
      e.word = RD_CMD16; e.last = 1'b0; expQ.push_back(e);
      e.word = wrCmd;    e.last = 1'b0; expQ.push_back(e);
      for (int i = 0; i < nExp; i++) begin
         e.word = PW'(i + 1);
         e.last = (i == nExp - 1);
         expQ.push_back(e);
      end
      startPulse = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      startPulse = 1'b0;
      chk1("fnh_clear", netFnh, 1'b0);
      for (int c = 0; c < 400 && !netFnh; c++) begin
         @(posedge clk);
         #1;
      end
      chk1("done", netFnh, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      chk("q_empty", PW'(expQ.size()), '0);
      chk1("idle_oe", datOe, 1'b1);
      chk1("idle_vld", ioVld, 1'b0);
      chk1("fnh_sticky", netFnh, 1'b1);
      for (int i = 0; i < nExp; i++) chk("dram_wb", dram[32'h1000 + i], PW'(i + 1));
      chk("dram_extra", dram[32'h1000 + nExp], '0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) dram[i] = PW'(i + 1);
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_oe", datOe, 1'b1);
      chk1("rst_vld", ioVld, 1'b0);
      chk1("rst_last", ioLast, 1'b0);
      chk("rst_dat", ioDat, '0);
      chk1("rst_fnh", netFnh, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      runJob(1'b1, 1'b0, 0, WR_CMD16, 16);
      runJob(1'b0, 1'b1, 0, WR_CMD16, 16);
      runJob(1'b1, 1'b0, 5, WR_CMD5, 5);

      // Reset in the middle of the read burst, then a clean job.
      begin
         exp_t e;
         stallEn   = 1'b0;
         earlyLast = 0;
         e.word = RD_CMD16; e.last = 1'b0; expQ.push_back(e);
         startPulse = 1'b1;
         for (int c = 0; c < 50 && datOe; c++) begin
            @(posedge clk);
            #1;
         end
         chk1("oe_rd", datOe, 1'b0);
         repeat (4) @(posedge clk);
         #1;
         rst_n = 1'b0;
         expQ.delete();
         #1;
         chk1("mid_rst_oe", datOe, 1'b1);
         chk1("mid_rst_vld", ioVld, 1'b0);
         chk("mid_rst_dat", ioDat, '0);
         chk1("mid_rst_fnh", netFnh, 1'b0);
         startPulse = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      runJob(1'b1, 1'b0, 0, WR_CMD16, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
